// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for serial_subtractor.
// ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one registered borrow cell.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             d_bit;
  logic             bout;
  logic             last;
`ifdef SERIAL_SUB_OVF_EN
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             ovf_q, ovf_d;
`endif

  assign d_bit = a_q[0] ^ b_q[0] ^ bin_q;
  assign bout  = (~a_q[0] & b_q[0])
               | (~(a_q[0] ^ b_q[0]) & bin_q);
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    am_d     = am_q;
    bm_d     = bm_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          bin_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
          am_d    = bus.a[WIDTH-1];
          bm_d    = bus.b[WIDTH-1];
`endif
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = {d_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bin_d = bout;
        cnt_d = cnt_q + 1'b1;
        // the last bit processed is also the result MSB
        if (last) begin
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (am_q != bm_q) & (d_bit != am_q);
`endif
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am_q     <= 1'b0;
      bm_q     <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      am_q     <= am_d;
      bm_q     <= bm_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Random and directed bench for serial_subtractor at WIDTH 8 and 2.
// Checks every cycle against a countdown/arithmetic reference model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(2)) if2 ();

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8));
  serial_subtractor #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int         wv[2] = '{8, 2};
  logic       m_busy[2] = '{1'b0, 1'b0};
  logic       m_done[2] = '{1'b0, 1'b0};
  int         m_left[2] = '{0, 0};
  logic [7:0] m_diff[2] = '{8'h0, 8'h0};
  logic       m_bor[2]  = '{1'b0, 1'b0};
  logic       m_ovf[2]  = '{1'b0, 1'b0};
  logic [7:0] p_diff[2] = '{8'h0, 8'h0};
  logic       p_bor[2]  = '{1'b0, 1'b0};
  logic       p_ovf[2]  = '{1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void ref_sub(input int w, input int a, input int b,
                                  output logic [7:0] d, output logic bo,
                                  output logic ov);
    int lim, sa, sb, r;
    lim = 1 << w;
    d   = 8'((a - b + lim) % lim);
    bo  = (a < b);
    sa  = (a >= lim / 2) ? a - lim : a;
    sb  = (b >= lim / 2) ? b - lim : b;
    r   = sa - sb;
    ov  = (r < -(lim / 2)) || (r >= lim / 2);
  endfunction

  // reference: accept when idle, result appears WIDTH edges later
  always @(posedge clk) begin
    logic st[2];
    int ia[2], ib[2];
    logic [7:0] td;
    logic tbo, tov;
    st[0] = if8.start; ia[0] = int'(if8.a); ib[0] = int'(if8.b);
    st[1] = if2.start; ia[1] = int'(if2.a); ib[1] = int'(if2.b);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_left[k] <= 0;
        m_diff[k] <= 8'h0; m_bor[k] <= 1'b0; m_ovf[k] <= 1'b0;
      end else if (m_busy[k]) begin
        m_left[k] <= m_left[k] - 1;
        if (m_left[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_diff[k] <= p_diff[k];
          m_bor[k]  <= p_bor[k];
          m_ovf[k]  <= p_ovf[k];
        end
      end else begin
        m_done[k] <= 1'b0;
        if (st[k]) begin
          ref_sub(wv[k], ia[k], ib[k], td, tbo, tov);
          p_diff[k] <= td; p_bor[k] <= tbo; p_ovf[k] <= tov;
          m_busy[k] <= 1'b1;
          m_left[k] <= wv[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", 32'(if8.busy), 32'(m_busy[0]));
      chk("done8", 32'(if8.done), 32'(m_done[0]));
      chk("diff8", 32'(if8.diff), 32'(m_diff[0]));
      chk("borrow8", 32'(if8.borrow), 32'(m_bor[0]));
      chk("busy2", 32'(if2.busy), 32'(m_busy[1]));
      chk("done2", 32'(if2.done), 32'(m_done[1]));
      chk("diff2", 32'(if2.diff), 32'(m_diff[1]));
      chk("borrow2", 32'(if2.borrow), 32'(m_bor[1]));
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf8", 32'(if8.ovf), 32'(m_ovf[0]));
      chk("ovf2", 32'(if2.ovf), 32'(m_ovf[1]));
`endif
    end
  end

  task automatic set_in(input int k, input logic s, input int a,
                        input int b);
    if (k == 0) begin
      if8.start = s; if8.a = 8'(a); if8.b = 8'(b);
    end else begin
      if2.start = s; if2.a = 2'(a); if2.b = 2'(b);
    end
  endtask

  function automatic logic get_done(input int k);
    return (k == 0) ? if8.done : if2.done;
  endfunction

  task automatic get_res(input int k, output logic [7:0] d,
                         output logic bo, output logic ov);
    ov = 1'b0;
    if (k == 0) begin
      d = if8.diff; bo = if8.borrow;
`ifdef SERIAL_SUB_OVF_EN
      ov = if8.ovf;
`endif
    end else begin
      d = {6'b0, if2.diff}; bo = if2.borrow;
`ifdef SERIAL_SUB_OVF_EN
      ov = if2.ovf;
`endif
    end
  endtask

  // call at a negedge; returns at the negedge inside the done cycle
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!get_done(k) && lat < 40);
    if (!get_done(k)) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: no done after %0d cycles", lat);
    end
  endtask

  task automatic op(input int k, input int a, input int b,
                    output logic [7:0] d, output logic bo,
                    output logic ov, output int lat);
    set_in(k, 1'b1, a, b);
    @(negedge clk);
    set_in(k, 1'b0, a, b);
    lat = 1;
    while (!get_done(k) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!get_done(k)) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: no done after %0d cycles", lat);
    end
    get_res(k, d, bo, ov);
  endtask

  task automatic directed(input int a, input int b, input int ed,
                          input logic eb, input logic eo,
                          input bit use_ovf);
    logic [7:0] d; logic bo, ov; int lat;
    op(0, a, b, d, bo, ov, lat);
    chk("lat_dir", 32'(lat), 32'd9);
    chk("diff_dir", 32'(d), 32'(ed));
    chk("borrow_dir", 32'(bo), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    if (use_ovf) chk("ovf_dir", 32'(ov), 32'(eo));
`else
    if (use_ovf && eo === 1'bx) $display("ovf feature disabled");
`endif
  endtask

  initial begin
    logic [7:0] d;
    logic bo, ov, rd_bo, rd_ov;
    logic [7:0] rd_d;
    int lat, ndone, ra, rb;
    set_in(0, 1'b0, 0, 0);
    set_in(1, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_diff", 32'(if8.diff), 32'h0);
    chk("rst_busy", 32'(if8.busy), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    directed(8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b1);
    directed(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b1);
    directed(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
    directed(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    directed(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
    directed(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);

    // start held, operands scrambled during SHIFT, back-to-back issue
    set_in(0, 1'b1, 8'h35, 8'h12);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!get_done(0)) set_in(0, 1'b1, $urandom, $urandom);
    end while (!get_done(0) && lat < 40);
    chk("b2b_lat1", 32'(lat), 32'd9);
    chk("b2b_diff1", 32'(if8.diff), 32'h23);
    set_in(0, 1'b1, 8'h12, 8'h35);
    @(negedge clk);
    set_in(0, 1'b1, $urandom, $urandom);
    wait_done(0, lat);
    chk("b2b_lat2", 32'(lat + 1), 32'd9);
    chk("b2b_diff2", 32'(if8.diff), 32'hDD);
    chk("b2b_bor2", 32'(if8.borrow), 32'h1);
    set_in(0, 1'b0, 0, 0);
    @(negedge clk);

    // reset at edge 4 of an operation
    set_in(0, 1'b1, 8'h35, 8'h12);
    @(negedge clk);
    set_in(0, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_busy", 32'(if8.busy), 32'h0);
    chk("rst_mid_done", 32'(if8.done), 32'h0);
    chk("rst_mid_diff", 32'(if8.diff), 32'h0);
    chk("rst_mid_bor", 32'(if8.borrow), 32'h0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'h0);
    directed(8'hAA, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = int'($urandom_range(0, (1 << wv[k]) - 1));
        rb = int'($urandom_range(0, (1 << wv[k]) - 1));
        op(k, ra, rb, d, bo, ov, lat);
        ref_sub(wv[k], ra, rb, rd_d, rd_bo, rd_ov);
        chk("rnd_lat", 32'(lat), 32'(wv[k] + 1));
        chk("rnd_diff", 32'(d), 32'(rd_d));
        chk("rnd_borrow", 32'(bo), 32'(rd_bo));
`ifdef SERIAL_SUB_OVF_EN
        chk("rnd_ovf", 32'(ov), 32'(rd_ov));
`endif
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
